// File: rtl/pa_wb_sequencer.sv
// Fetch PC generator plus multi-lane writeback merge FIFO that drains to the register file.
// Same-register writes within a cycle keep only the youngest lane, and the PC stalls when FIFO space runs low.
module pa_wb_sequencer #(
    parameter int LANES      = 2,
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 5,
    parameter int PC_W       = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [LANES-1:0]              wbEn_i,
    input  logic [LANES*ADDR_W-1:0]       wbAddr_i,
    input  logic [LANES*DATA_W-1:0]       wbVal_i,
    input  logic                          redirect_i,
    input  logic [PC_W-1:0]               redirectPc_i,
    input  logic                          ready_i,
    output logic [PC_W-1:0]               pc_o,
    output logic                          stall_o,
    output logic                          wbValid_o,
    output logic [ADDR_W-1:0]             wbAddr_o,
    output logic [DATA_W-1:0]             wbVal_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount_o,
    output logic                          overflow_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addrMemR [FIFO_DEPTH];
    logic [DATA_W-1:0] valMemR  [FIFO_DEPTH];
    logic [PTR_W-1:0]  headR;
    logic [PTR_W-1:0]  tailR;
    logic [CNT_W-1:0]  countR;

    logic [LANES-1:0]  surviveS;
    logic [LANES-1:0]  laneWriteS;
    logic [PTR_W-1:0]  slotS [LANES];
    logic [CNT_W-1:0]  pushCntS;
    logic [CNT_W-1:0]  freeS;
    logic              popS;
    logic              dropS;

    // Head presentation and status derived from registered FIFO state.
    always_comb begin
        wbValid_o   = (countR != {CNT_W{1'b0}});
        popS        = wbValid_o && ready_i;
        stall_o     = ((CNT_W'(FIFO_DEPTH) - countR) < CNT_W'(LANES));
        fifoCount_o = countR;
        freeS       = CNT_W'(FIFO_DEPTH) - countR + CNT_W'(popS);
        if (wbValid_o) begin
            wbAddr_o = addrMemR[headR];
            wbVal_o  = valMemR[headR];
        end else begin
            wbAddr_o = {ADDR_W{1'b0}};
            wbVal_o  = {DATA_W{1'b0}};
        end
    end

    // Drop an older lane whenever a younger lane targets the same register this cycle.
    always_comb begin
        surviveS = wbEn_i;
        for (int j = 0; j < LANES - 1; j++) begin
            for (int k = j + 1; k < LANES; k++) begin
                surviveS[j] = surviveS[j] &
                    ~(wbEn_i[k] && (wbAddr_i[j*ADDR_W +: ADDR_W] == wbAddr_i[k*ADDR_W +: ADDR_W]));
            end
        end
    end

    // Allocate FIFO slots to survivors in lane order; lanes past the free space are lost.
    always_comb begin
        pushCntS   = {CNT_W{1'b0}};
        dropS      = 1'b0;
        laneWriteS = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            slotS[k] = {PTR_W{1'b0}};
            if (surviveS[k]) begin
                if (pushCntS < freeS) begin
                    laneWriteS[k] = 1'b1;
                    slotS[k]      = tailR + pushCntS[PTR_W-1:0];
                    pushCntS      = pushCntS + CNT_W'(1);
                end else begin
                    dropS = 1'b1;
                end
            end else begin
                slotS[k] = {PTR_W{1'b0}};
            end
        end
    end

    // FIFO storage, pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            headR      <= {PTR_W{1'b0}};
            tailR      <= {PTR_W{1'b0}};
            countR     <= {CNT_W{1'b0}};
            overflow_o <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addrMemR[i] <= {ADDR_W{1'b0}};
                valMemR[i]  <= {DATA_W{1'b0}};
            end
        end else begin
            for (int k = 0; k < LANES; k++) begin
                if (laneWriteS[k]) begin
                    addrMemR[slotS[k]] <= wbAddr_i[k*ADDR_W +: ADDR_W];
                    valMemR[slotS[k]]  <= wbVal_i[k*DATA_W +: DATA_W];
                end
            end
            tailR      <= tailR + pushCntS[PTR_W-1:0];
            headR      <= headR + PTR_W'(popS);
            countR     <= countR + pushCntS - CNT_W'(popS);
            overflow_o <= overflow_o | dropS;
        end
    end

    // Fetch PC: redirect beats stall, otherwise advance by the lane count.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pc_o <= {PC_W{1'b0}};
        end else if (redirect_i) begin
            pc_o <= redirectPc_i;
        end else if (!stall_o) begin
            pc_o <= pc_o + PC_W'(LANES);
        end else begin
            pc_o <= pc_o;
        end
    end

endmodule

// File: tb/tb_pa_wb_sequencer.sv
// Directed bench for pa_wb_sequencer (LANES=2, DEPTH=8): PC stepping, conflict merge,
// fill/overflow, redirect under stall, PC wrap and asynchronous reset mid-drain.
module tb_pa_wb_sequencer;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [1:0]  wbEn_i;
    logic [9:0]  wbAddr_i;
    logic [31:0] wbVal_i;
    logic        redirect_i;
    logic [15:0] redirectPc_i;
    logic        ready_i;
    logic [15:0] pc_o;
    logic        stall_o;
    logic        wbValid_o;
    logic [4:0]  wbAddr_o;
    logic [15:0] wbVal_o;
    logic [3:0]  fifoCount_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    pa_wb_sequencer dut (
        .clock_i(clock_i), .reset_i(reset_i), .wbEn_i(wbEn_i), .wbAddr_i(wbAddr_i),
        .wbVal_i(wbVal_i), .redirect_i(redirect_i), .redirectPc_i(redirectPc_i),
        .ready_i(ready_i), .pc_o(pc_o), .stall_o(stall_o), .wbValid_o(wbValid_o),
        .wbAddr_o(wbAddr_o), .wbVal_o(wbVal_o), .fifoCount_o(fifoCount_o),
        .overflow_o(overflow_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic setLanes(input logic [1:0] en, input logic [4:0] a0, input logic [15:0] v0,
                            input logic [4:0] a1, input logic [15:0] v1);
        wbEn_i   = en;
        wbAddr_i = {a1, a0};
        wbVal_i  = {v1, v0};
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_pc"}, 32'(pc_o), 32'h0);
        checkVal({tag, "_valid"}, 32'(wbValid_o), 32'h0);
        checkVal({tag, "_addr"}, 32'(wbAddr_o), 32'h0);
        checkVal({tag, "_val"}, 32'(wbVal_o), 32'h0);
        checkVal({tag, "_count"}, 32'(fifoCount_o), 32'h0);
        checkVal({tag, "_stall"}, 32'(stall_o), 32'h0);
        checkVal({tag, "_ovf"}, 32'(overflow_o), 32'h0);
    endtask

    initial begin
        reset_i      = 1'b0;
        setLanes(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        redirect_i   = 1'b0;
        redirectPc_i = 16'h0000;
        ready_i      = 1'b1;
        #1;
        checkAllZero("reset");
        #9;
        reset_i = 1'b1;
        #1;
        checkVal("pc_start", 32'(pc_o), 32'h0);

        // PC advances by 2 per clock with nothing in the FIFO
        for (int i = 1; i <= 4; i++) begin
            tick();
            checkVal("pc_step", 32'(pc_o), 32'(2 * i));
            checkVal("idle_valid", 32'(wbValid_o), 32'h0);
        end

        // Two distinct lanes drain in lane order
        setLanes(2'b11, 5'd3, 16'h0011, 5'd7, 16'h0022);
        tick();
        setLanes(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        checkVal("t2_count0", 32'(fifoCount_o), 32'd2);
        checkVal("t2_valid0", 32'(wbValid_o), 32'h1);
        checkVal("t2_addr0", 32'(wbAddr_o), 32'd3);
        checkVal("t2_val0", 32'(wbVal_o), 32'h0011);
        tick();
        checkVal("t2_count1", 32'(fifoCount_o), 32'd1);
        checkVal("t2_addr1", 32'(wbAddr_o), 32'd7);
        checkVal("t2_val1", 32'(wbVal_o), 32'h0022);
        tick();
        checkVal("t2_count2", 32'(fifoCount_o), 32'd0);
        checkVal("t2_valid2", 32'(wbValid_o), 32'h0);
        checkVal("t2_addr2", 32'(wbAddr_o), 32'h0);
        checkVal("t2_pc", 32'(pc_o), 32'd14);

        // Same register on both lanes: younger lane wins, one entry
        ready_i = 1'b0;
        setLanes(2'b11, 5'd4, 16'hAAAA, 5'd4, 16'hBBBB);
        tick();
        setLanes(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        checkVal("t3_count", 32'(fifoCount_o), 32'd1);
        checkVal("t3_addr", 32'(wbAddr_o), 32'd4);
        checkVal("t3_val", 32'(wbVal_o), 32'hBBBB);
        checkVal("t3_ovf", 32'(overflow_o), 32'h0);
        ready_i = 1'b1;
        tick();
        checkVal("t3_drained", 32'(fifoCount_o), 32'd0);
        tick();
        checkVal("empty_ready_count", 32'(fifoCount_o), 32'd0);
        checkVal("empty_ready_valid", 32'(wbValid_o), 32'h0);
        checkVal("t3_pc", 32'(pc_o), 32'd20);

        // Fill with ready low: stall once free < 2, fifth pair overflows
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            setLanes(2'b11, 5'(10 + 2 * i), 16'(16'h0100 + 2 * i),
                     5'(11 + 2 * i), 16'(16'h0101 + 2 * i));
            tick();
            checkVal("t4_count", 32'(fifoCount_o), (i < 3) ? 32'(2 * (i + 1)) : 32'd8);
            checkVal("t4_stall", 32'(stall_o), (i < 3) ? 32'h0 : 32'h1);
            checkVal("t4_ovf", 32'(overflow_o), (i < 4) ? 32'h0 : 32'h1);
            checkVal("t4_pc", 32'(pc_o), (i < 3) ? 32'(22 + 2 * i) : 32'd28);
        end
        setLanes(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        checkVal("t4_head_addr", 32'(wbAddr_o), 32'd10);
        checkVal("t4_head_val", 32'(wbVal_o), 32'h0100);

        // Redirect overrides stall, then PC holds
        redirect_i   = 1'b1;
        redirectPc_i = 16'h0100;
        tick();
        redirect_i = 1'b0;
        checkVal("t5_pc_redirect", 32'(pc_o), 32'h0100);
        tick();
        checkVal("t5_pc_hold", 32'(pc_o), 32'h0100);
        checkVal("t5_head_stable", 32'(wbAddr_o), 32'd10);

        // Full FIFO with pop: one slot frees, lane 1 dropped
        ready_i = 1'b1;
        setLanes(2'b11, 5'd20, 16'h0300, 5'd21, 16'h0301);
        tick();
        setLanes(2'b00, 5'd0, 16'h0, 5'd0, 16'h0);
        checkVal("full_pop_count", 32'(fifoCount_o), 32'd8);
        checkVal("full_pop_addr", 32'(wbAddr_o), 32'd11);
        checkVal("full_pop_val", 32'(wbVal_o), 32'h0101);
        checkVal("full_pop_pc", 32'(pc_o), 32'h0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkVal("drain_count", 32'(fifoCount_o), 32'(7 - i));
            checkVal("drain_addr", 32'(wbAddr_o), 32'(12 + i));
            checkVal("drain_val", 32'(wbVal_o), 32'(16'h0102 + i));
        end

        // PC wrap with three entries still queued
        ready_i      = 1'b0;
        redirect_i   = 1'b1;
        redirectPc_i = 16'hFFFE;
        tick();
        redirect_i = 1'b0;
        checkVal("t6_pc_fffe", 32'(pc_o), 32'hFFFE);
        tick();
        checkVal("t6_pc_wrap", 32'(pc_o), 32'h0000);
        tick();
        checkVal("t6_pc_after", 32'(pc_o), 32'h0002);
        checkVal("t6_count", 32'(fifoCount_o), 32'd3);
        checkVal("t6_ovf_sticky", 32'(overflow_o), 32'h1);

        // Asynchronous reset mid-drain clears outputs before the next edge
        ready_i = 1'b1;
        #2;
        reset_i = 1'b0;
        #1;
        checkAllZero("async_reset");
        #2;
        reset_i = 1'b1;
        tick();
        checkVal("post_reset_pc", 32'(pc_o), 32'h0002);
        checkVal("post_reset_count", 32'(fifoCount_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
